// File: rtl/alarm_pkg.sv
// alarm_unit shared types, limits and defaults.
// Imported by the alarm stage and its tooling.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RINGING,
    SNOOZE
  } state_e;

  localparam logic [3:0] MAX_HH = 4'd12;
  localparam logic [5:0] MAX_MM = 6'd59;

  localparam int RING_SEC_DEF   = 60;
  localparam int SNOOZE_SEC_DEF = 300;
  localparam int MAX_SNOOZE_DEF = 3;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sec_down_counter.sv
// Seconds down-counter shared by the ring and snooze periods.
// done_o flags the last second of the loaded period.
module sec_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/alarm_unit.sv
// Alarm stage: compares the time-of-day counter with the stored
// alarm and drives ring with timeout, limited snooze and stop.
module alarm_unit
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = RING_SEC_DEF,
  parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
  parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] hh,
  input  logic [5:0] mm,
  input  logic [5:0] ss,
  input  logic       pm,
  input  logic       arm,
  input  logic       set_alarm,
  input  logic [3:0] a_hh,
  input  logic [5:0] a_mm,
  input  logic       a_pm,
  input  logic       snooze,
  input  logic       stop,
  output logic       ring,
  output logic       armed,
  output logic       snoozing,
  output logic       set_err,
  output logic [3:0] al_hh,
  output logic [5:0] al_mm,
  output logic       al_pm
);

  localparam int CW = $clog2(max_i(RING_SEC, SNOOZE_SEC) + 1);
  localparam int SW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  state_e          state_q, state_d;
  logic [SW-1:0]   sn_q, sn_d;
  logic [3:0]      al_hh_q, al_hh_d;
  logic [5:0]      al_mm_q, al_mm_d;
  logic            al_pm_q, al_pm_d;
  logic            match, match_q, trig, set_ok;
  logic            ring_q, armed_q, snoozing_q, set_err_q;
  logic            ld, cnt_en, cnt_done;
  logic [CW-1:0]   ld_val;

  assign set_ok = set_alarm && (a_hh <= MAX_HH) && (a_mm <= MAX_MM);
  assign match  = (hh == al_hh_q) && (mm == al_mm_q) &&
                  (pm == al_pm_q) && (ss == 6'd0);
  // Edge detect: a stalled time counter cannot retrigger
  assign trig   = match && !match_q;
  assign cnt_en = (state_q == RINGING) || (state_q == SNOOZE);

  always_comb begin
    state_d = state_q;
    sn_d    = sn_q;
    ld      = 1'b0;
    ld_val  = CW'(RING_SEC);
    al_hh_d = al_hh_q;
    al_mm_d = al_mm_q;
    al_pm_d = al_pm_q;
    if (set_ok) begin
      al_hh_d = a_hh;
      al_mm_d = a_mm;
      al_pm_d = a_pm;
    end
    if (!arm) begin
      state_d = IDLE;
    end else if (set_ok) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (trig) begin
            state_d = RINGING;
            ld      = 1'b1;
            sn_d    = '0;
          end
        end
        RINGING: begin
          if (stop) begin
            state_d = ARMED;
          end else if (snooze && sn_q < SW'(MAX_SNOOZE)) begin
            state_d = SNOOZE;
            ld      = 1'b1;
            ld_val  = CW'(SNOOZE_SEC);
            sn_d    = sn_q + 1'b1;
          end else if (cnt_done) begin
            state_d = ARMED;
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_d = ARMED;
          end else if (cnt_done) begin
            state_d = RINGING;
            ld      = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  sec_down_counter #(
    .W(CW)
  ) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .load_i (ld),
    .val_i  (ld_val),
    .en_i   (cnt_en),
    .done_o (cnt_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sn_q       <= '0;
      match_q    <= 1'b0;
      al_hh_q    <= '0;
      al_mm_q    <= '0;
      al_pm_q    <= 1'b0;
      ring_q     <= 1'b0;
      armed_q    <= 1'b0;
      snoozing_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sn_q       <= sn_d;
      match_q    <= match;
      al_hh_q    <= al_hh_d;
      al_mm_q    <= al_mm_d;
      al_pm_q    <= al_pm_d;
      ring_q     <= (state_d == RINGING);
      armed_q    <= (state_d != IDLE);
      snoozing_q <= (state_d == SNOOZE);
      set_err_q  <= set_alarm && !set_ok;
    end
  end

  assign ring     = ring_q;
  assign armed    = armed_q;
  assign snoozing = snoozing_q;
  assign set_err  = set_err_q;
  assign al_hh    = al_hh_q;
  assign al_mm    = al_mm_q;
  assign al_pm    = al_pm_q;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed self-checking bench for alarm_unit
// with RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2.
module tb_alarm_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;
  logic       pm;
  logic       arm;
  logic       set_alarm;
  logic [3:0] a_hh;
  logic [5:0] a_mm;
  logic       a_pm;
  logic       snooze;
  logic       stop;
  logic       ring;
  logic       armed;
  logic       snoozing;
  logic       set_err;
  logic [3:0] al_hh;
  logic [5:0] al_mm;
  logic       al_pm;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alarm_unit #(
    .RING_SEC  (4),
    .SNOOZE_SEC(3),
    .MAX_SNOOZE(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .hh       (hh),
    .mm       (mm),
    .ss       (ss),
    .pm       (pm),
    .arm      (arm),
    .set_alarm(set_alarm),
    .a_hh     (a_hh),
    .a_mm     (a_mm),
    .a_pm     (a_pm),
    .snooze   (snooze),
    .stop     (stop),
    .ring     (ring),
    .armed    (armed),
    .snoozing (snoozing),
    .set_err  (set_err),
    .al_hh    (al_hh),
    .al_mm    (al_mm),
    .al_pm    (al_pm)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trigger(input logic [3:0] h,
                         input logic [5:0] m,
                         input logic p);
    hh = h; mm = m; pm = p; ss = 6'd59;
    tick();
    ss = 6'd0;
    tick();
    ss = 6'd1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    hh = 4'd1; mm = 6'd0; ss = 6'd5; pm = 1'b0;
    arm = 1'b0; set_alarm = 1'b0;
    a_hh = '0; a_mm = '0; a_pm = 1'b0;
    snooze = 1'b0; stop = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    n_chk++;
    if ({ring, armed, snoozing, set_err, al_hh, al_mm, al_pm} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected all zero",
               {ring, armed, snoozing, set_err, al_hh, al_mm, al_pm});
    end
  endtask

  task automatic test_ring();
    set_alarm = 1'b1; a_hh = 4'd7; a_mm = 6'd30; a_pm = 1'b0; arm = 1'b1;
    tick();
    set_alarm = 1'b0;
    n_chk++;
    if ({armed, al_hh, al_mm, al_pm} !== {1'b1, 4'd7, 6'd30, 1'b0}) begin
      n_fail++;
      $display("FAIL set_0730: armed=%b al=%0d:%0d pm=%b expected 1 7:30 0",
               armed, al_hh, al_mm, al_pm);
    end
    hh = 4'd7; mm = 6'd29; ss = 6'd59; pm = 1'b0;
    tick();
    n_chk++;
    if (ring !== 1'b0) begin
      n_fail++;
      $display("FAIL ring_early: ring=%b expected 0", ring);
    end
    mm = 6'd30; ss = 6'd0;
    tick();
    ss = 6'd1;
    n_chk++;
    if (ring !== 1'b1) begin
      n_fail++;
      $display("FAIL ring_latency: ring=%b expected 1", ring);
    end
    for (int i = 1; i < 4; i++) begin
      tick();
      n_chk++;
      if (ring !== 1'b1) begin
        n_fail++;
        $display("FAIL ring_hold[%0d]: ring=%b expected 1", i, ring);
      end
    end
    tick();
    n_chk++;
    if ({ring, armed} !== 2'b01) begin
      n_fail++;
      $display("FAIL ring_timeout: ring,armed=%b expected 01", {ring, armed});
    end
  endtask

  task automatic test_snooze();
    trigger(4'd7, 6'd30, 1'b0);
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    n_chk++;
    if ({ring, snoozing} !== 2'b01) begin
      n_fail++;
      $display("FAIL snooze1_enter: ring,snoozing=%b expected 01", {ring, snoozing});
    end
    for (int i = 1; i < 3; i++) begin
      tick();
      n_chk++;
      if (ring !== 1'b0) begin
        n_fail++;
        $display("FAIL snooze1_quiet[%0d]: ring=%b expected 0", i, ring);
      end
    end
    tick();
    n_chk++;
    if ({ring, snoozing} !== 2'b10) begin
      n_fail++;
      $display("FAIL snooze1_wake: ring,snoozing=%b expected 10", {ring, snoozing});
    end
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    n_chk++;
    if ({ring, snoozing} !== 2'b01) begin
      n_fail++;
      $display("FAIL snooze2_enter: ring,snoozing=%b expected 01", {ring, snoozing});
    end
    tick();
    tick();
    tick();
    n_chk++;
    if (ring !== 1'b1) begin
      n_fail++;
      $display("FAIL snooze2_wake: ring=%b expected 1", ring);
    end
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    n_chk++;
    if ({ring, snoozing} !== 2'b10) begin
      n_fail++;
      $display("FAIL snooze3_ignored: ring,snoozing=%b expected 10", {ring, snoozing});
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_chk++;
    if ({ring, armed, snoozing} !== 3'b010) begin
      n_fail++;
      $display("FAIL stop_ring: ring,armed,snoozing=%b expected 010",
               {ring, armed, snoozing});
    end
  endtask

  task automatic test_stop_snooze();
    trigger(4'd7, 6'd30, 1'b0);
    n_chk++;
    if (ring !== 1'b1) begin
      n_fail++;
      $display("FAIL retrigger: ring=%b expected 1", ring);
    end
    stop = 1'b1;
    snooze = 1'b1;
    tick();
    stop = 1'b0;
    snooze = 1'b0;
    n_chk++;
    if ({ring, armed, snoozing} !== 3'b010) begin
      n_fail++;
      $display("FAIL stop_beats_snooze: ring,armed,snoozing=%b expected 010",
               {ring, armed, snoozing});
    end
  endtask

  task automatic test_set_err();
    set_alarm = 1'b1; a_hh = 4'd7; a_mm = 6'd60; a_pm = 1'b0;
    tick();
    set_alarm = 1'b0;
    n_chk++;
    if ({set_err, al_mm} !== {1'b1, 6'd30}) begin
      n_fail++;
      $display("FAIL set_mm60: set_err=%b al_mm=%0d expected 1 30", set_err, al_mm);
    end
    tick();
    n_chk++;
    if (set_err !== 1'b0) begin
      n_fail++;
      $display("FAIL set_err_pulse: set_err=%b expected 0", set_err);
    end
    set_alarm = 1'b1; a_hh = 4'd13; a_mm = 6'd0;
    tick();
    set_alarm = 1'b0;
    n_chk++;
    if ({set_err, al_hh} !== {1'b1, 4'd7}) begin
      n_fail++;
      $display("FAIL set_hh13: set_err=%b al_hh=%0d expected 1 7", set_err, al_hh);
    end
    set_alarm = 1'b1; a_hh = 4'd12; a_mm = 6'd0; a_pm = 1'b1;
    tick();
    set_alarm = 1'b0;
    n_chk++;
    if ({set_err, al_hh, al_mm, al_pm} !== {1'b0, 4'd12, 6'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL set_1200pm: set_err=%b al=%0d:%0d pm=%b expected 0 12:0 1",
               set_err, al_hh, al_mm, al_pm);
    end
  endtask

  task automatic test_hold();
    int hi;
    int rises;
    logic prev;
    hh = 4'd12; mm = 6'd0; pm = 1'b1; ss = 6'd59;
    tick();
    ss = 6'd0;
    hi = 0;
    rises = 0;
    prev = ring;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ring) hi++;
      if (ring && !prev) rises++;
      prev = ring;
    end
    n_chk++;
    if (rises !== 1) begin
      n_fail++;
      $display("FAIL hold_events: events=%0d expected 1", rises);
    end
    n_chk++;
    if (hi !== 4) begin
      n_fail++;
      $display("FAIL hold_ring_len: cycles=%0d expected 4", hi);
    end
    pm = 1'b0;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ring) hi++;
    end
    n_chk++;
    if (hi !== 0) begin
      n_fail++;
      $display("FAIL pm_mismatch: ring cycles=%0d expected 0", hi);
    end
  endtask

  task automatic test_reset_arm();
    pm = 1'b1;
    tick();
    ss = 6'd1;
    n_chk++;
    if (ring !== 1'b1) begin
      n_fail++;
      $display("FAIL pm_trigger: ring=%b expected 1", ring);
    end
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    n_chk++;
    if (snoozing !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_snooze: snoozing=%b expected 1", snoozing);
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({ring, armed, snoozing, set_err, al_hh, al_mm, al_pm} !== 15'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected all zero",
               {ring, armed, snoozing, set_err, al_hh, al_mm, al_pm});
    end
    tick();
    reset_n = 1'b1;
    set_alarm = 1'b1; a_hh = 4'd8; a_mm = 6'd15; a_pm = 1'b1;
    tick();
    set_alarm = 1'b0;
    n_chk++;
    if ({armed, al_hh, al_mm, al_pm} !== {1'b1, 4'd8, 6'd15, 1'b1}) begin
      n_fail++;
      $display("FAIL rearm_set: armed=%b al=%0d:%0d pm=%b expected 1 8:15 1",
               armed, al_hh, al_mm, al_pm);
    end
    trigger(4'd8, 6'd15, 1'b1);
    arm = 1'b0;
    #1;
    n_chk++;
    if (ring !== 1'b1) begin
      n_fail++;
      $display("FAIL ring_before_disarm: ring=%b expected 1", ring);
    end
    tick();
    n_chk++;
    if ({ring, armed, snoozing} !== 3'b000) begin
      n_fail++;
      $display("FAIL disarm_idle: ring,armed,snoozing=%b expected 000",
               {ring, armed, snoozing});
    end
  endtask

  initial begin
    test_reset();
    test_ring();
    test_snooze();
    test_stop_snooze();
    test_set_err();
    test_hold();
    test_reset_arm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
